// File: rtl/mcp4822_pkg.sv
// Shared types and constants for the MCP4822 DAC SPI write path.
// Frame layout, FSM states and the command-word builder.
package mcp4822_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    LDAC_P
  } state_t;

  localparam int CH_BIT       = 15;
  localparam int GA_BIT       = 13;
  localparam int SHDN_BIT     = 12;
  localparam int FRAME_BITS   = 16;
  localparam int SCK_HALF_DEF = 70;

  function automatic logic [FRAME_BITS-1:0] dac_word(
    input logic        ch,
    input logic        ga,
    input logic [11:0] data
  );
    logic [FRAME_BITS-1:0] w;
    w           = {4'b0000, data};
    w[CH_BIT]   = ch;
    w[GA_BIT]   = ga;
    w[SHDN_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/mcp4822_dac_spi_tx_half_tick.sv
// Half-period tick generator: one-cycle tick every SCK_HALF clocks.
// Ports: clk, rst (sync high), en (count enable, clears when low), tick.
module spi_half_tick
  import mcp4822_pkg::*;
#(
  parameter int SCK_HALF = SCK_HALF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(SCK_HALF - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mcp4822_dac_spi_tx.sv
// MCP4822 write master: 16-bit SPI mode-0 frame, then an LDAC pulse.
// In: clk, rst, i_DATA/i_DATA_VALID/i_CH. Out: MOSI, SCK, CS, LDAC,
// o_BUSY, o_DONE, o_OVERRUN (all registered).
module mcp4822_dac_spi_tx
  import mcp4822_pkg::*;
#(
  parameter int SCK_HALF = SCK_HALF_DEF,
  parameter int GAIN_1X  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_DATA,
  input  logic        i_DATA_VALID,
  input  logic        i_CH,
  output logic        MOSI,
  output logic        SCK,
  output logic        CS,
  output logic        LDAC,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_OVERRUN
);

  localparam int HW = $clog2(2 * FRAME_BITS);
  localparam logic [HW-1:0] LAST = HW'(2 * FRAME_BITS - 1);

  state_t state, state_d;

  logic                  tick;
  logic                  launch;
  logic [FRAME_BITS-1:0] word;
  logic [FRAME_BITS-1:0] sr, sr_d;
  logic [12:0]           pend, pend_d;
  logic                  pend_full, pend_full_d;
  logic [HW-1:0]         hcnt, hcnt_d;
  logic mosi_d, sck_d, cs_d, ldac_d;
  logic busy_d, done_d, ovr_d;

  spi_half_tick #(.SCK_HALF(SCK_HALF)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  assign launch = (state == IDLE) &&
                  (pend_full || i_DATA_VALID);

  // Pending sample wins over a fresh strobe at launch.
  assign word = pend_full ?
    dac_word(pend[12], 1'(GAIN_1X), pend[11:0]) :
    dac_word(i_CH, 1'(GAIN_1X), i_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      hcnt      <= '0;
      MOSI      <= 1'b0;
      SCK       <= 1'b0;
      CS        <= 1'b1;
      LDAC      <= 1'b1;
      o_BUSY    <= 1'b0;
      o_DONE    <= 1'b0;
      o_OVERRUN <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      pend      <= pend_d;
      pend_full <= pend_full_d;
      hcnt      <= hcnt_d;
      MOSI      <= mosi_d;
      SCK       <= sck_d;
      CS        <= cs_d;
      LDAC      <= ldac_d;
      o_BUSY    <= busy_d;
      o_DONE    <= done_d;
      o_OVERRUN <= ovr_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (launch) state_d = SHIFT;
      SHIFT:   if (tick && hcnt == LAST) state_d = GAP;
      GAP:     if (tick) state_d = LDAC_P;
      LDAC_P:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d        = sr;
    pend_d      = pend;
    pend_full_d = pend_full;
    hcnt_d      = hcnt;
    mosi_d      = MOSI;
    sck_d       = SCK;
    cs_d        = CS;
    ldac_d      = LDAC;
    busy_d      = o_BUSY;
    done_d      = 1'b0;
    ovr_d       = 1'b0;

    // A strobe in IDLE with pending full refills pending
    // (its old content is launching, so no overrun).
    if (i_DATA_VALID && (state != IDLE || pend_full)) begin
      pend_d      = {i_CH, i_DATA};
      pend_full_d = 1'b1;
      ovr_d       = pend_full && (state != IDLE);
    end else if (state == IDLE && pend_full) begin
      pend_full_d = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (launch) begin
          sr_d   = word;
          mosi_d = word[FRAME_BITS-1];
          cs_d   = 1'b0;
          sck_d  = 1'b0;
          busy_d = 1'b1;
          hcnt_d = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          hcnt_d = hcnt + 1'b1;
          if (!hcnt[0]) begin
            sck_d = 1'b1;
          end else if (hcnt == LAST) begin
            sck_d  = 1'b0;
            cs_d   = 1'b1;
            mosi_d = 1'b0;
          end else begin
            sck_d  = 1'b0;
            mosi_d = sr[FRAME_BITS-2];
            sr_d   = {sr[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (tick) ldac_d = 1'b0;
      end
      LDAC_P: begin
        if (tick) begin
          ldac_d = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mcp4822_dac_spi_tx.sv
// Self-checking bench for mcp4822_dac_spi_tx.
// Two instances: SCK_HALF=70/1x gain and SCK_HALF=2/2x gain.
module tb_mcp4822_dac_spi_tx;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst;
  logic [11:0] d;
  logic        ch;
  logic        v1, v2;
  logic mosi1, sck1, cs1, ldac1, busy1, done1, ovr1;
  logic mosi2, sck2, cs2, ldac2, busy2, done2, ovr2;

  int n_chk = 0;
  int n_err = 0;

  mcp4822_dac_spi_tx #(.SCK_HALF(70), .GAIN_1X(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_DATA       (d),
    .i_DATA_VALID (v1),
    .i_CH         (ch),
    .MOSI         (mosi1),
    .SCK          (sck1),
    .CS           (cs1),
    .LDAC         (ldac1),
    .o_BUSY       (busy1),
    .o_DONE       (done1),
    .o_OVERRUN    (ovr1)
  );

  mcp4822_dac_spi_tx #(.SCK_HALF(2), .GAIN_1X(0)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .i_DATA       (d),
    .i_DATA_VALID (v2),
    .i_CH         (ch),
    .MOSI         (mosi2),
    .SCK          (sck2),
    .CS           (cs2),
    .LDAC         (ldac2),
    .o_BUSY       (busy2),
    .o_DONE       (done2),
    .o_OVERRUN    (ovr2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic c, input logic [11:0] x,
                      input bit sel);
    @(negedge clk);
    ch = c;
    d  = x;
    if (sel) v2 = 1'b1;
    else     v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  typedef struct {
    logic [15:0] word;
    int cs_low;
    int ldac_off;
    int ldac_len;
    int done_off;
    int mosi_bad;
    int ovr_cnt;
    int hi_tail;
    int pre_wait;
    bit to;
  } frame_t;

  // Follows one frame from CS falling to o_DONE, sampling on negedge.
  task automatic mon(input bit sel, output frame_t f);
    logic cs, sck, mosi, ldac, done, ovr;
    logic psck, pmosi;
    f = '{word: '0, cs_low: 0, ldac_off: -1, ldac_len: 0,
          done_off: -1, mosi_bad: 0, ovr_cnt: 0, hi_tail: 0,
          pre_wait: -1, to: 1'b1};
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!(sel ? cs2 : cs1)) begin
        f.pre_wait = t;
        break;
      end
    end
    if (f.pre_wait < 0) return;
    psck  = 1'b0;
    pmosi = sel ? mosi2 : mosi1;
    for (int k = 0; k < 8000; k++) begin
      cs   = sel ? cs2   : cs1;
      sck  = sel ? sck2  : sck1;
      mosi = sel ? mosi2 : mosi1;
      ldac = sel ? ldac2 : ldac1;
      done = sel ? done2 : done1;
      ovr  = sel ? ovr2  : ovr1;
      if (!cs) f.cs_low++;
      else     f.hi_tail++;
      if (k > 0 && sck && !psck) f.word = {f.word[14:0], mosi};
      if (mosi != pmosi && sck) f.mosi_bad++;
      if (!ldac) begin
        if (f.ldac_off < 0) f.ldac_off = k;
        f.ldac_len++;
      end
      if (ovr) f.ovr_cnt++;
      if (done) begin
        f.done_off = k;
        f.to = 1'b0;
        break;
      end
      psck  = sck;
      pmosi = mosi;
      @(negedge clk);
    end
  endtask

  frame_t fa, fb;
  int     cnt;

  initial begin
    rst = 1'b1;
    d   = '0;
    ch  = 1'b0;
    v1  = 1'b0;
    v2  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cs", cs1, 1);
    chk("rst_ldac", ldac1, 1);
    chk("rst_sck", sck1, 0);
    chk("rst_mosi", mosi1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ovr", ovr1, 0);

    // Single frame, channel A
    fork
      mon(0, fa);
      send(0, 12'hD73, 0);
    join
    chk("f1_to", fa.to, 0);
    chk("f1_word", fa.word, 32'h3D73);
    chk("f1_cs_low", fa.cs_low, 2240);
    chk("f1_ldac_off", fa.ldac_off, 2310);
    chk("f1_ldac_len", fa.ldac_len, 70);
    chk("f1_done_off", fa.done_off, 2380);
    chk("f1_mosi", fa.mosi_bad, 0);
    @(negedge clk);
    chk("f1_done_1cyc", done1, 0);
    chk("f1_busy_off", busy1, 0);

    // Channel B
    fork
      mon(0, fa);
      send(1, 12'h003, 0);
    join
    chk("f2_to", fa.to, 0);
    chk("f2_word", fa.word, 32'hB003);
    chk("f2_mosi", fa.mosi_bad, 0);

    // Mid-frame sample goes back-to-back
    fork
      begin
        mon(0, fa);
        mon(0, fb);
      end
      begin
        send(0, 12'h456, 0);
        repeat (1000) @(negedge clk);
        send(0, 12'h123, 0);
      end
    join
    chk("b2b_w1", fa.word, 32'h3456);
    chk("b2b_ovr", fa.ovr_cnt + fb.ovr_cnt, 0);
    chk("b2b_start", fb.pre_wait, 0);
    chk("b2b_gap", fa.hi_tail + fb.pre_wait, 141);
    chk("b2b_w2", fb.word, 32'h3123);
    chk("b2b_to", fb.to, 0);

    // Overrun: latest pending sample wins
    fork
      begin
        mon(0, fa);
        mon(0, fb);
      end
      begin
        send(0, 12'h111, 0);
        repeat (500) @(negedge clk);
        send(0, 12'h222, 0);
        repeat (500) @(negedge clk);
        send(0, 12'h333, 0);
      end
    join
    chk("ovr_w1", fa.word, 32'h3111);
    chk("ovr_cnt", fa.ovr_cnt, 1);
    chk("ovr_w2", fb.word, 32'h3333);
    chk("ovr_cnt2", fb.ovr_cnt, 0);
    chk("ovr_start", fb.pre_wait, 0);

    // Reset during bit 7 with a sample pending
    send(0, 12'h555, 0);
    for (int t = 0; t < 50 && cs1; t++) @(negedge clk);
    chk("rst_mid_start", cs1, 0);
    repeat (500) @(negedge clk);
    send(0, 12'h777, 0);
    repeat (14 * 70 - 502 + 5) @(negedge clk);
    chk("rst_mid_sck_lo", sck1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_cs", cs1, 1);
    chk("rst_mid_sck", sck1, 0);
    chk("rst_mid_ldac", ldac1, 1);
    chk("rst_mid_busy", busy1, 0);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (!cs1 || !ldac1) cnt++;
    end
    chk("rst_pend_empty", cnt, 0);
    fork
      mon(0, fa);
      send(0, 12'hABC, 0);
    join
    chk("rst_after_w", fa.word, 32'h3ABC);
    chk("rst_after_done", fa.done_off, 2380);

    // Fast instance, 2x gain
    fork
      mon(1, fa);
      send(0, 12'hD73, 1);
    join
    chk("f2x_to", fa.to, 0);
    chk("f2x_word", fa.word, 32'h1D73);
    chk("f2x_cs_low", fa.cs_low, 64);
    chk("f2x_ldac_off", fa.ldac_off, 66);
    chk("f2x_ldac_len", fa.ldac_len, 2);
    chk("f2x_done_off", fa.done_off, 68);
    chk("f2x_mosi", fa.mosi_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
